data_bus_memory: RTL and testbench
==================================

# data_bus_memory

Line-granular main-memory model that sits directly downstream of the pipeline's data bus, after the mux between the data cache's refill/writeback port and the accelerator's bus port. It accepts one whole-line read or write request at a time and holds it for a fixed, parameterised latency. It then completes the request with a one-cycle finish handshake. It is the only agent that answers `data_bus_read_request` and `data_bus_write_request`.

## Interface
- `LINE_ADDR_LEN`, default 3: log2 of words per line; line width is 32·2^LINE_ADDR_LEN bits (256 at default).
- `MEM_ADDR_LEN`, default 10: log2 of the number of lines stored.
- `LATENCY`, default 8: cycles from request acceptance to finish. Legal range is 1..255.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `read_request`  in  1  level request for a line read; held until finish is seen.
- `write_request`  in  1  level request for a line write; held until finish is seen.
- `addr`  in  32  byte address. Offset bits [LINE_ADDR_LEN+1:0] are ignored.
- `write_data`  in  32·2^LINE_ADDR_LEN  line to write. Word 0 is in bits [31:0].
- `request_finish`  out  1  one-cycle completion pulse.
- `read_data`  out  32·2^LINE_ADDR_LEN  last line read. Held between reads.
- `busy`  out  1  high in every state except IDLE.

## Operation
- Line index is `addr[LINE_ADDR_LEN+2 +: MEM_ADDR_LEN]`. Address bits above the index are ignored, so addresses alias modulo 2^MEM_ADDR_LEN lines.
- State machine states: IDLE, BUSY, DONE, DRAIN.
- IDLE: when either request is high, the block latches the operation, line index and write_data, loads the counter with LATENCY−1, and moves to BUSY.
  - If both requests are high, it is a write. Write has priority and no read occurs.
- BUSY: the counter decrements each cycle. When the counter reaches 0, the block moves to DONE.
  - Changes to the request inputs, `addr` or `write_data` during BUSY are ignored; the latched values are used.
- DONE: `request_finish`=1 for exactly this cycle. On the exit edge:
  - a write commits the latched line to the array;
  - a read loads `read_data` from the array.
  - Next state is IDLE if both requests are low, otherwise DRAIN.
- DRAIN: waits until both requests are low, then moves to IDLE. This prevents a request that is held one cycle too long from being served twice.
- `read_data` changes only on a read's DONE exit edge. Writes never disturb it.
- Reset, async, at any time including mid-request:
  - state returns to IDLE, counter to 0;
  - `request_finish`=0, `busy`=0, `read_data`=0;
  - any pending write is dropped.
  - Array contents are not cleared.

## Timing
- Request sampled high at edge E0 (state IDLE). `busy`=1 from E0.
- `request_finish` is high in the cycle that follows edge E0+LATENCY.
- The commit or read update happens at edge E0+LATENCY+1.
- With LATENCY=1, BUSY lasts one cycle and DONE follows immediately.
- A requester that drops its request on the edge where it samples finish gets back-to-back service: the next request can be accepted at edge E0+LATENCY+2 with no DRAIN cycle.
- Read-after-write to the same line returns the new data, because the write commits before the next acceptance.
- All outputs are registered, with no combinational paths from inputs to outputs.

## Structure
- The shared package holds the state encoding, `LINE_WIDTH = 32<<LINE_ADDR_LEN`, and a function that extracts the line index.
- Sub-module `mem_line_array`: synchronous single-port line RAM with write-enable, index, write line and read line (registered). It holds no reset logic.
- The top module holds the state machine, the counter and the request latches.

## Test plan
- **Write then read, LATENCY=8.** Write line of words 0x11..0x88 to addr 0x0000_0040, then read the same address → `request_finish` 8 cycles after each acceptance; `read_data` equals the written line.
- **Inputs changed mid-BUSY.** Start a read of 0x40, then change `addr` to 0x80 and assert `write_request` during BUSY → the read of 0x40 completes and no write occurs.
- **Simultaneous requests.** Assert read and write together with write_data 0xDEADBEEF×8 at 0x100 → write performed; `read_data` unchanged; a later read returns 0xDEADBEEF×8.
- **Held request.** Hold `read_request` 3 cycles after finish → state DRAIN; exactly one `request_finish` pulse; IDLE one cycle after the drop.
- **Reset mid-write.** Assert `rst` 3 cycles into a write to 0x200 → all outputs 0 immediately; a subsequent read of 0x200 returns the pre-write contents.
- **Aliasing.** With MEM_ADDR_LEN=10, write to 0x0000_0020, then read 0x0000_8020 → same line returned.

Source files
------------

// File: rtl/data_bus_memory_pkg.sv
// -----------------------------------------------------------------------------
// data_bus_memory_pkg
//   Shared definitions for the line-granular data-bus memory model:
//     - state_t      : request state machine encoding
//     - line_width() : line width in bits for a given LINE_ADDR_LEN
//     - line_index() : extracts the line index from a byte address
// -----------------------------------------------------------------------------
package data_bus_memory_pkg;

   localparam int unsigned DEF_LINE_ADDR_LEN = 3;
   localparam int unsigned DEF_MEM_ADDR_LEN  = 10;
   localparam int unsigned LINE_WIDTH        = 32 << DEF_LINE_ADDR_LEN;
   localparam int unsigned CNT_W             = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BUSY  = 2'd1,
      ST_DONE  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   function automatic int unsigned line_width(input int unsigned line_addr_len);
      return 32 << line_addr_len;
   endfunction

   // Drops the word/byte offset, then keeps MEM_ADDR_LEN index bits so that
   // higher address bits alias onto the same line.
   function automatic logic [31:0] line_index(input logic [31:0]  addr,
                                               input int unsigned line_addr_len,
                                               input int unsigned mem_addr_len);
      logic [31:0] mask;
      mask = (32'd1 << mem_addr_len) - 32'd1;
      return (addr >> (line_addr_len + 2)) & mask;
   endfunction

endpackage

// File: rtl/data_bus_memory_mem_line_array.sv
// -----------------------------------------------------------------------------
// mem_line_array
//   Synchronous single-port line RAM. Read data is registered and reflects the
//   array contents at idx_i as of the previous rising edge. No reset: the array
//   and the read register keep their contents across system reset.
//   Ports:
//     clk_i    in   clock
//     we_i     in   write enable
//     idx_i    in   line index (read and write share the port)
//     wdata_i  in   line to write
//     rdata_o  out  registered read line
// -----------------------------------------------------------------------------
module mem_line_array #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 256
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] idx_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[idx_i] <= wdata_i;
      end
      rdata_q <= mem_q[idx_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_bus_memory.sv
// -----------------------------------------------------------------------------
// data_bus_memory
//   Line-granular main-memory model on the pipeline data bus. Accepts one
//   whole-line read or write at a time, holds it for LATENCY cycles, then
//   signals completion with a one-cycle request_finish pulse.
//   Ports:
//     clk            in   clock, rising edge
//     rst            in   asynchronous active-high reset
//     read_request   in   level read request, held until finish
//     write_request  in   level write request, held until finish (wins ties)
//     addr           in   byte address; offset bits ignored
//     write_data     in   line to write, word 0 in [31:0]
//     request_finish out  one-cycle completion pulse
//     read_data      out  last line read, held between reads
//     busy           out  high whenever the state machine is not IDLE
// -----------------------------------------------------------------------------
module data_bus_memory
   import data_bus_memory_pkg::*;
#(
   parameter  int unsigned LINE_ADDR_LEN = 3,
   parameter  int unsigned MEM_ADDR_LEN  = 10,
   parameter  int unsigned LATENCY       = 8,
   localparam int unsigned LW            = 32 << LINE_ADDR_LEN
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          read_request,
   input  logic          write_request,
   input  logic [31:0]   addr,
   input  logic [LW-1:0] write_data,
   output logic          request_finish,
   output logic [LW-1:0] read_data,
   output logic          busy
);

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic                    is_write_q;
   logic [MEM_ADDR_LEN-1:0] idx_q;
   logic [LW-1:0]           wline_q;
   logic                    finish_q;
   logic                    busy_q;
   logic [LW-1:0]           rdata_q;

   logic                    ram_we;
   logic [LW-1:0]           ram_rdata;
   logic                    any_req;
   logic [MEM_ADDR_LEN-1:0] req_idx;

   assign any_req = read_request | write_request;
   assign req_idx = MEM_ADDR_LEN'(line_index(addr, LINE_ADDR_LEN, MEM_ADDR_LEN));

   // The commit happens on the DONE exit edge; reset forces IDLE, so a write
   // interrupted by reset never reaches the array.
   assign ram_we = (state_q == ST_DONE) && is_write_q;

   mem_line_array #(
      .ADDR_W (MEM_ADDR_LEN),
      .DATA_W (LW)
   ) u_array (
      .clk_i   (clk),
      .we_i    (ram_we),
      .idx_i   (idx_q),
      .wdata_i (wline_q),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         is_write_q <= 1'b0;
         idx_q      <= '0;
         wline_q    <= '0;
         finish_q   <= 1'b0;
         busy_q     <= 1'b0;
         rdata_q    <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (any_req) begin
                  state_q    <= ST_BUSY;
                  busy_q     <= 1'b1;
                  is_write_q <= write_request;
                  idx_q      <= req_idx;
                  wline_q    <= write_data;
                  cnt_q      <= CNT_W'(LATENCY - 1);
               end
            end
            ST_BUSY: begin
               if (cnt_q == '0) begin
                  state_q  <= ST_DONE;
                  finish_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            ST_DONE: begin
               finish_q <= 1'b0;
               // The RAM read register has tracked idx_q since acceptance, and
               // nothing writes the array while a request is in flight.
               if (!is_write_q) begin
                  rdata_q <= ram_rdata;
               end
               if (any_req) begin
                  state_q <= ST_DRAIN;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if (!any_req) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign request_finish = finish_q;
   assign busy           = busy_q;
   assign read_data      = rdata_q;

endmodule

// File: tb/tb_data_bus_memory.sv
module tb_data_bus_memory;

   localparam int unsigned LW      = 256;
   localparam int unsigned LATENCY = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          rreq, wreq;
   logic [31:0]   addr;
   logic [LW-1:0] wdata, rdata;
   logic          fin, busy;

   always #5 clk = ~clk;

   data_bus_memory #(
      .LINE_ADDR_LEN (3),
      .MEM_ADDR_LEN  (10),
      .LATENCY       (LATENCY)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .read_request   (rreq),
      .write_request  (wreq),
      .addr           (addr),
      .write_data     (wdata),
      .request_finish (fin),
      .read_data      (rdata),
      .busy           (busy)
   );

   int            total = 0;
   int            fails = 0;
   logic [LW-1:0] model [int];
   logic [LW-1:0] exp_rd;
   logic [LW-1:0] sb_q [$];

   function automatic int midx(input logic [31:0] a);
      return int'((a >> 5) & 32'h3FF);
   endfunction

   function automatic logic [LW-1:0] ramp_line(input logic [31:0] step);
      logic [LW-1:0] l;
      for (int i = 0; i < 8; i++) l[i*32 +: 32] = step * 32'(i + 1);
      return l;
   endfunction

   task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] expv);
      total++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One complete request: drive, await finish, optionally hold, drop, check.
   task automatic do_req(input string tag, input logic w, input logic r,
                         input logic [31:0] a, input logic [LW-1:0] wd,
                         input int unsigned hold, input bit perturb);
      int unsigned cyc;
      int unsigned pulses;
      @(negedge clk);
      check({tag, ":idle_before"}, LW'(busy), LW'(1'b0));
      rreq  = r;
      wreq  = w;
      addr  = a;
      wdata = wd;
      if (w) model[midx(a)] = wd;
      else   exp_rd = model[midx(a)];
      sb_q.push_back(exp_rd);
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) check({tag, ":busy_after_accept"}, LW'(busy), LW'(1'b1));
         if (perturb && cyc == 3) begin
            addr  = 32'h0000_0080;
            wreq  = 1'b1;
            wdata = {8{32'hBAD0_BAD0}};
         end
      end while (!fin && cyc < 40);
      check({tag, ":finish_latency"}, LW'(cyc), LW'(LATENCY + 1));
      pulses = 1;
      repeat (hold) begin
         @(negedge clk);
         if (fin) pulses++;
         check({tag, ":drain_busy"}, LW'(busy), LW'(1'b1));
      end
      rreq = 1'b0;
      wreq = 1'b0;
      @(negedge clk);
      if (fin) pulses++;
      check({tag, ":idle_after"}, LW'(busy), LW'(1'b0));
      check({tag, ":pulse_count"}, LW'(pulses), LW'(1));
      check({tag, ":read_data"}, rdata, sb_q.pop_front());
   endtask

   initial begin
      logic [LW-1:0] line_a, line_b, line_c, line_d, line_e;
      line_a = ramp_line(32'h11);
      line_b = ramp_line(32'h0101_0101);
      line_c = ramp_line(32'h0C0C_0003);
      line_d = ramp_line(32'h0D0D_0007);
      line_e = ramp_line(32'h0E0E_0005);

      rst = 1'b1; rreq = 1'b0; wreq = 1'b0; addr = '0; wdata = '0;
      exp_rd = '0;
      #12;
      check("reset:finish", LW'(fin), LW'(1'b0));
      check("reset:busy", LW'(busy), LW'(1'b0));
      check("reset:read_data", rdata, '0);
      @(negedge clk);
      rst = 1'b0;

      // Write then read back
      do_req("wr40", 1'b1, 1'b0, 32'h0000_0040, line_a, 0, 1'b0);
      do_req("rd40", 1'b0, 1'b1, 32'h0000_0040, '0, 0, 1'b0);

      // Inputs changed mid-BUSY must be ignored
      do_req("wr80", 1'b1, 1'b0, 32'h0000_0080, line_b, 0, 1'b0);
      do_req("rd40_perturb", 1'b0, 1'b1, 32'h0000_0040, '0, 0, 1'b1);
      do_req("rd80_intact", 1'b0, 1'b1, 32'h0000_0080, '0, 0, 1'b0);

      // Simultaneous requests resolve to a write
      do_req("both100", 1'b1, 1'b1, 32'h0000_0100, {8{32'hDEAD_BEEF}}, 0, 1'b0);
      do_req("rd100", 1'b0, 1'b1, 32'h0000_0100, '0, 0, 1'b0);

      // Held request goes through DRAIN with a single finish pulse
      do_req("rd40_hold", 1'b0, 1'b1, 32'h0000_0040, '0, 3, 1'b0);

      // Reset during a write drops it
      do_req("wr200", 1'b1, 1'b0, 32'h0000_0200, line_c, 0, 1'b0);
      @(negedge clk);
      wreq = 1'b1; addr = 32'h0000_0200; wdata = line_d;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst:finish", LW'(fin), LW'(1'b0));
      check("midrst:busy", LW'(busy), LW'(1'b0));
      check("midrst:read_data", rdata, '0);
      @(negedge clk);
      rst = 1'b0; wreq = 1'b0;
      exp_rd = '0;
      do_req("rd200_old", 1'b0, 1'b1, 32'h0000_0200, '0, 0, 1'b0);

      // Address aliasing modulo 2^MEM_ADDR_LEN lines
      do_req("wr20", 1'b1, 1'b0, 32'h0000_0020, line_e, 0, 1'b0);
      do_req("rd8020", 1'b0, 1'b1, 32'h0000_8020, '0, 0, 1'b0);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
